// File: rtl/sram_confreg_responder.sv
// Data-SRAM target: synchronous word RAM plus a config-register window (LED, NUM, SWITCH, TIMER).
// Define CONFREG_TIMER_EN to build the free-running timer at offset 0xe000.
module sram_confreg_responder #(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [15:0] CONF_BASE = 16'h1faf,
  parameter int unsigned SW_W      = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic [3:0]      wen,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [SW_W-1:0] switch_in,
  output logic [15:0]     led_out,
  output logic [31:0]     num_out
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam logic [15:0] OFF_LED   = 16'hf000;
  localparam logic [15:0] OFF_NUM   = 16'hf010;
  localparam logic [15:0] OFF_SW    = 16'hf020;
  localparam logic [15:0] OFF_TIMER = 16'he000;

  logic [31:0]       mem [RAM_DEPTH];
  logic              conf_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       conf_off;
  logic [31:0]       ram_rd;
  logic [31:0]       conf_rd;
  logic [15:0]       led_q;
  logic [31:0]       num_q;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [15:0]       led_next;
  logic [15:0]       led_merge_unused;
  logic [31:0]       num_next;
  logic              led_we;
  logic              num_we;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] nxt,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = nxt[8*i +: 8];
    end
    return r;
  endfunction

  assign conf_sel = (addr[31:16] == CONF_BASE);
  assign conf_off = addr[15:0];
  assign ram_idx  = addr[RAM_AW+1:2];
  assign ram_rd   = mem[ram_idx];
  assign led_we   = en && conf_sel && (conf_off == OFF_LED);
  assign num_we   = en && conf_sel && (conf_off == OFF_NUM);

  always_comb begin
    {led_merge_unused, led_next} = byte_merge({16'h0000, led_q}, wdata, wen);
    num_next = byte_merge(num_q, wdata, wen);
  end

`ifdef CONFREG_TIMER_EN
  logic [31:0] timer_q;
  logic        timer_we;

  assign timer_we = en && conf_sel && (conf_off == OFF_TIMER) && (wen != '0);

  // A load takes the place of that edge's increment; counting resumes from the loaded value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timer_q <= '0;
    else if (timer_we) timer_q <= byte_merge(timer_q, wdata, wen);
    else timer_q <= timer_q + 32'd1;
  end
`endif

  always_comb begin
    conf_rd = '0;
    case (conf_off)
      OFF_LED:   conf_rd = {16'h0000, led_q};
      OFF_NUM:   conf_rd = num_q;
      OFF_SW:    conf_rd = 32'(sw_sync);
`ifdef CONFREG_TIMER_EN
      OFF_TIMER: conf_rd = timer_q;
`endif
      default:   conf_rd = '0;
    endcase
  end

  // Writes attempted while reset is asserted are dropped, RAM included.
  always_ff @(posedge clk) begin
    if (resetn && en && !conf_sel) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wen[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata   <= '0;
      led_q   <= '0;
      num_q   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
      if (en) rdata <= conf_sel ? conf_rd : ram_rd;
      if (led_we) led_q <= led_next;
      if (num_we) num_q <= num_next;
    end
  end

  assign led_out = led_q;
  assign num_out = num_q;

endmodule

// File: tb/tb_sram_confreg_responder.sv
// Directed bench for sram_confreg_responder: read expectations queued at issue, checked when rdata is valid.
module tb_sram_confreg_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  switch_in = '0;
  logic [15:0] led_out;
  logic [31:0] num_out;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] t_exp0, t_exp1, t_exp2;

  always #5 clk = ~clk;

  sram_confreg_responder #(
    .RAM_AW(12),
    .CONF_BASE(16'h1faf),
    .SW_W(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .wen(wen),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .switch_in(switch_in),
    .led_out(led_out),
    .num_out(num_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // One clock: drive, cross the rising edge, settle 1 time unit.
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0; wen = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    cyc(1'b1, w, a, d);
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] expv,
                        input logic [3:0] w, input logic [31:0] d);
    exp_q.push_back(expv);
    cyc(1'b1, w, a, d);
    check(tag, rdata, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout rdata=%h expected=finish", rdata);
    $fatal(1, "timeout");
  end

  initial begin
`ifdef CONFREG_TIMER_EN
    t_exp0 = 32'hffff_fffe; t_exp1 = 32'hffff_ffff; t_exp2 = 32'h0000_0000;
`else
    t_exp0 = '0; t_exp1 = '0; t_exp2 = '0;
`endif
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);
    check("reset_num", num_out, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    wr(32'h0000_0040, 32'h1234_5678, 4'hf);
    rd_exp("ram_word", 32'h0000_0040, 32'h1234_5678, 4'h0, 32'h0);

    wr(32'h0000_0040, 32'hAABB_CCDD, 4'hf);
    wr(32'h0000_0040, 32'h1122_3344, 4'b0101);
    rd_exp("byte_merge", 32'h0000_0040, 32'hAA22_CC44, 4'h0, 32'h0);
    rd_exp("ram_alias", 32'h0000_4040, 32'hAA22_CC44, 4'h0, 32'h0);

    wr(32'h0000_0080, 32'h0000_0005, 4'hf);
    rd_exp("read_first", 32'h0000_0080, 32'h0000_0005, 4'hf, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'h0, 32'h0000_0040, 32'hffff_ffff);
      check("rdata_hold", rdata, 32'h0000_0005);
    end
    rd_exp("after_collision", 32'h0000_0080, 32'h0000_0000, 4'h0, 32'h0);

    wr(32'h1faf_f000, 32'hFFFF_A5A5, 4'hf);
    check("led_write", {16'h0, led_out}, 32'h0000_A5A5);
    rd_exp("led_read", 32'h1faf_f000, 32'h0000_A5A5, 4'h0, 32'h0);
    wr(32'h1faf_f000, 32'h0000_3C00, 4'b0010);
    check("led_byte", {16'h0, led_out}, 32'h0000_3CA5);

    wr(32'h1faf_f010, 32'hDEAD_BEEF, 4'hf);
    check("num_write", num_out, 32'hDEAD_BEEF);
    wr(32'h1faf_f010, 32'h1200_0000, 4'b1000);
    check("num_byte", num_out, 32'h12AD_BEEF);
    rd_exp("num_read", 32'h1faf_f010, 32'h12AD_BEEF, 4'h0, 32'h0);

    rd_exp("unmapped_read", 32'h1faf_f0ff, 32'h0, 4'h0, 32'h0);
    wr(32'h1faf_f0ff, 32'h5555_5555, 4'hf);
    check("unmapped_led", {16'h0, led_out}, 32'h0000_3CA5);
    check("unmapped_num", num_out, 32'h12AD_BEEF);

    // Switch changes with setup before edge n; edge n has no access.
    switch_in = 8'h3C;
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    rd_exp("switch_n1", 32'h1faf_f020, 32'h0000_0000, 4'h0, 32'h0);
    rd_exp("switch_n2", 32'h1faf_f020, 32'h0000_003C, 4'h0, 32'h0);

    wr(32'h1faf_e000, 32'hFFFF_FFFE, 4'hf);
    rd_exp("timer_0", 32'h1faf_e000, t_exp0, 4'h0, 32'h0);
    rd_exp("timer_1", 32'h1faf_e000, t_exp1, 4'h0, 32'h0);
    rd_exp("timer_2", 32'h1faf_e000, t_exp2, 4'h0, 32'h0);

    #2;
    resetn = 1'b0;
    #1;
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_led", {16'h0, led_out}, 32'h0);
    check("midreset_num", num_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    rd_exp("timer_after_reset", 32'h1faf_e000, 32'h0, 4'h0, 32'h0);
    rd_exp("ram_retained", 32'h0000_0040, 32'hAA22_CC44, 4'h0, 32'h0);
    rd_exp("switch_after_reset", 32'h1faf_f020, 32'h0000_003C, 4'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
